// File: rtl/mem_port_arbiter8.sv
// Round-robin arbiter sharing one memory port among eight requesters.
// Grants are held until resp or the optional watchdog ends the transaction.
module mem_port_arbiter8 #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       resp,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       mem_valid,
  output logic [7:0] done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  localparam logic [7:0] LP_TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t     r_state, w_state_nx;
  logic [2:0] r_ptr, r_sel;
  logic [7:0] r_gnt, r_cnt;
  logic       r_terr;
  logic [2:0] w_win, w_idx;
  logic       w_any, w_wd_fire, w_end;

  // Scan from the farthest index back to ptr so the nearest set bit wins last.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    w_any = |req;
    for (int k = 7; k >= 0; k--) begin
      w_idx = r_ptr + 3'(k);
      if (req[w_idx]) w_win = w_idx;
    end
  end

  // resp in the last watchdog cycle takes precedence over the timeout.
  assign w_wd_fire = (TIMEOUT != 0) && (r_cnt == LP_TO_LAST) && !resp;
  assign w_end     = resp || w_wd_fire;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nx = S_BUSY;
      S_BUSY:  if (w_end) w_state_nx = S_GAP;
      S_GAP:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_terr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt <= 8'b1 << w_win;
            r_sel <= w_win;
            r_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (w_end) begin
            r_gnt  <= '0;
            r_ptr  <= r_sel + 3'd1;
            r_terr <= w_wd_fire;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel         = r_sel;
  assign gnt         = r_gnt;
  assign mem_valid   = (r_state == S_BUSY);
  assign done        = r_gnt & {8{resp}};
  assign timeout_err = r_terr;

endmodule
